clock_phase_sampler: RTL and testbench

- Responder end of the sample_req / sample_valid clock-alignment handshake.
- Clocked by one phase of the master ADC clock. Samples the slave ADC clock as asynchronous data over a fixed window, majority-votes the result, and flags edge proximity.
- The alignment FSM runs in another domain. It raises sample_req and waits for sample_valid on all phase instances, then reads dout/sample_error to decide whether to re-reset the slave ADC.

---
 rtl/clock_sync_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/clock_phase_sampler.sv | 132 +++++++++++++
 tb/tb_clock_phase_sampler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_sync_pkg.sv
// Shared types and defaults for the clock phase sampler.
// Latency: none (package only).
// Backpressure: none (package only).
package clock_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned DEF_SAMPLE_COUNT  = 16;
    localparam int unsigned DEF_SETTLE_CYCLES = 4;
    localparam int unsigned DEF_ERR_MARGIN    = 2;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Latency: 2 clock cycles.
// Backpressure: none; the output follows the input continuously.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a full cycle to resolve.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/clock_phase_sampler.sv
// Samples the slave ADC clock over a fixed window and majority-votes it.
// Latency: sample_valid rises SETTLE_CYCLES+SAMPLE_COUNT+3 cycles after sample_req.
// Backpressure: four-phase handshake; result held until sample_req drops.
module clock_phase_sampler
    import clock_sync_pkg::*;
#(
    parameter int unsigned SAMPLE_COUNT  = DEF_SAMPLE_COUNT,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned ERR_MARGIN    = DEF_ERR_MARGIN,
    localparam int unsigned CW           = clog2(SAMPLE_COUNT + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          din,
    input  logic          sample_req,
    output logic          dout,
    output logic          sample_valid,
    output logic          sample_error,
    output logic          sample_idle,
    output logic [CW-1:0] ones_count
);

    logic          din_s;
    logic          req_s;

    state_t        state_q;
    logic [7:0]    cyc_cnt_q;
    logic [CW-1:0] acc_q;
    logic [CW-1:0] acc_d;
    logic [CW-1:0] minority_d;
    logic          dout_q;
    logic          valid_q;
    logic          error_q;
    logic          idle_q;
    logic [CW-1:0] ones_q;

    sync_2ff u_sync_din (
        .clock (clock),
        .reset (reset),
        .d     (din),
        .q     (din_s)
    );

    sync_2ff u_sync_req (
        .clock (clock),
        .reset (reset),
        .d     (sample_req),
        .q     (req_s)
    );

    // Running count including this cycle's sample, and the smaller of ones/zeros.
    always_comb begin
        acc_d      = acc_q + CW'(din_s);
        minority_d = acc_d;
        if (acc_d > CW'(SAMPLE_COUNT / 2)) begin
            minority_d = CW'(SAMPLE_COUNT) - acc_d;
        end
    end

    // Handshake FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cyc_cnt_q <= '0;
            acc_q     <= '0;
            dout_q    <= 1'b0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            idle_q    <= 1'b1;
            ones_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_s) begin
                        state_q   <= ST_SETTLE;
                        cyc_cnt_q <= '0;
                        idle_q    <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (!req_s) begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                    end else if (cyc_cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                        state_q   <= ST_SAMPLE;
                        cyc_cnt_q <= '0;
                        acc_q     <= '0;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (!req_s) begin
                        // Aborted window: previous results stay visible.
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                    end else begin
                        acc_q     <= acc_d;
                        cyc_cnt_q <= cyc_cnt_q + 8'd1;
                        if (cyc_cnt_q == 8'(SAMPLE_COUNT - 1)) begin
                            state_q   <= ST_DONE;
                            cyc_cnt_q <= '0;
                            ones_q    <= acc_d;
                            dout_q    <= (acc_d > CW'(SAMPLE_COUNT / 2));
                            error_q   <= (minority_d > CW'(ERR_MARGIN));
                            valid_q   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!req_s) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        idle_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    idle_q  <= 1'b1;
                end
            endcase
        end
    end

    assign dout         = dout_q;
    assign sample_valid = valid_q;
    assign sample_error = error_q;
    assign sample_idle  = idle_q;
    assign ones_count   = ones_q;

endmodule

// File: tb/tb_clock_phase_sampler.sv
// Self-checking bench for clock_phase_sampler at default parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_clock_phase_sampler;

    logic       clock;
    logic       reset;
    logic       din;
    logic       sample_req;
    logic       dout;
    logic       sample_valid;
    logic       sample_error;
    logic       sample_idle;
    logic [4:0] ones_count;

    int errors = 0;
    int checks = 0;

    clock_phase_sampler dut (
        .clock        (clock),
        .reset        (reset),
        .din          (din),
        .sample_req   (sample_req),
        .dout         (dout),
        .sample_valid (sample_valid),
        .sample_error (sample_error),
        .sample_idle  (sample_idle),
        .ones_count   (ones_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] pat;
        logic        fill;
        int          ones;
        int          dout;
        int          err;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Raise req and drive din; pat[i] lands on the i-th din value the sampler
    // counts (din as seen at clock edges 6..21 after req is driven).
    task automatic run_req(input logic [15:0] pat, input logic [39:0] fp, output int vedge);
        vedge = -1;
        sample_req = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            if (n >= 6 && n <= 21) din = pat[4'(n - 6)];
            else                   din = fp[6'(n - 1)];
            @(negedge clock);
            if (sample_valid) begin
                vedge = n;
                break;
            end
        end
    endtask

    task automatic check_window(input string name, input logic [15:0] pat, input logic [39:0] fp,
                                input int eones, input int edout, input int eerr);
        int vedge;
        run_req(pat, fp, vedge);
        check({name, " valid_latency"}, vedge, 23);
        check({name, " ones_count"}, int'(ones_count), eones);
        check({name, " dout"}, int'(dout), edout);
        check({name, " sample_error"}, int'(sample_error), eerr);
        check({name, " idle_low"}, int'(sample_idle), 0);
    endtask

    task automatic release_req(input string name);
        int cnt;
        cnt = -1;
        sample_req = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            if (sample_idle) begin
                cnt = n;
                break;
            end
        end
        check({name, " idle_latency"}, cnt, 3);
        check({name, " valid_dropped"}, int'(sample_valid), 0);
    endtask

    // Reference: majority of the window, minority count against the margin.
    task automatic model(input logic [15:0] pat, output int k, output int d, output int e);
        int minor;
        k = 0;
        for (int i = 0; i < 16; i++) k += int'(pat[i]);
        minor = (k < 16 - k) ? k : 16 - k;
        d = (k > 8) ? 1 : 0;
        e = (minor > 2) ? 1 : 0;
    endtask

    initial begin
        int last_ones;
        int saw_valid;
        int saw_drop;
        int k, d, e;
        logic [15:0] rp;
        logic [39:0] rf;

        tbl[0] = '{16'hFFFF, 1'b0, 16, 1, 0};
        tbl[1] = '{16'h5555, 1'b1,  8, 0, 1};
        tbl[2] = '{16'h1FFF, 1'b0, 13, 1, 1};
        tbl[3] = '{16'h3FFF, 1'b0, 14, 1, 0};
        tbl[4] = '{16'h0000, 1'b1,  0, 0, 0};
        tbl[5] = '{16'h0007, 1'b1,  3, 0, 1};
        tbl[6] = '{16'h0003, 1'b1,  2, 0, 0};
        tbl[7] = '{16'h00FF, 1'b0,  8, 0, 1};
        tbl[8] = '{16'h01FF, 1'b0,  9, 1, 1};

        reset = 1'b1;
        din = 1'b0;
        sample_req = 1'b0;
        repeat (3) @(negedge clock);
        check("reset idle", int'(sample_idle), 1);
        check("reset valid", int'(sample_valid), 0);
        check("reset dout", int'(dout), 0);
        check("reset error", int'(sample_error), 0);
        check("reset ones", int'(ones_count), 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("idle no req", int'(sample_idle), 1);

        for (int i = 0; i < 9; i++) begin
            check_window($sformatf("tbl%0d", i), tbl[i].pat,
                         tbl[i].fill ? {40{1'b1}} : 40'd0,
                         tbl[i].ones, tbl[i].dout, tbl[i].err);
            release_req($sformatf("tbl%0d", i));
        end
        last_ones = tbl[8].ones;

        // Abort five samples into the window.
        sample_req = 1'b1;
        din = 1'b1;
        repeat (12) @(negedge clock);
        check("abort in_sample idle", int'(sample_idle), 0);
        sample_req = 1'b0;
        saw_valid = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clock);
            if (sample_valid) saw_valid = 1;
        end
        check("abort no valid", saw_valid, 0);
        check("abort idle", int'(sample_idle), 1);
        check("abort ones kept", int'(ones_count), last_ones);
        check("abort dout kept", int'(dout), 1);

        // Request after abort, then hold req high past DONE.
        check_window("post_abort", 16'hFFFF, 40'd0, 16, 1, 0);
        saw_drop = 0;
        for (int n = 0; n < 40; n++) begin
            din = 1'($urandom);
            @(negedge clock);
            if (!sample_valid) saw_drop = 1;
        end
        check("hold valid stays", saw_drop, 0);
        check("hold ones stable", int'(ones_count), 16);
        check("hold idle low", int'(sample_idle), 0);

        // Asynchronous reset while in DONE, between clock edges.
        #2 reset = 1'b1;
        #1;
        check("async_rst valid", int'(sample_valid), 0);
        check("async_rst dout", int'(dout), 0);
        check("async_rst error", int'(sample_error), 0);
        check("async_rst ones", int'(ones_count), 0);
        check("async_rst idle", int'(sample_idle), 1);
        sample_req = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_window("post_rst", 16'h1FFF, 40'd0, 13, 1, 1);
        release_req("post_rst");

        // Randomized windows against the reference model.
        for (int i = 0; i < 12; i++) begin
            rp = 16'($urandom);
            if (i % 3 == 0) rp = 16'hFFFF ^ (16'd1 << $urandom_range(15, 0));
            rf = {8'($urandom), 32'($urandom)};
            model(rp, k, d, e);
            check_window($sformatf("rnd%0d", i), rp, rf, k, d, e);
            repeat ($urandom_range(3, 0)) @(negedge clock);
            release_req($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
